// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// The FSM encoding lives here so the arbiter and its collaborators agree on it.
package uart_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_SEND = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_t;

  // Width of a counter or index that must hold values 0 .. n-1 (never zero bits wide).
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: one-hot selection of the first set request at or after rr_ptr.
// Purely combinational; the pointer itself is owned by the arbiter.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int PTR_W = cnt_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               any
);

  logic found;

  // NOTE: every variable written here is given a default first, so no latch is inferred.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      int idx;
      idx = int'(rr_ptr) + off;
      // Explicit wrap keeps the search correct for non-power-of-2 NUM_REQ.
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers, round-robin per burst.
// A burst ends on req_last, on a dropped req_valid, or after MAX_BURST bytes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DBIT      = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*DBIT-1:0] req_data,
  input  logic [NUM_REQ-1:0]      req_last,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    busy,
  output logic                    tx_start,
  output logic [DBIT-1:0]         tx_din,
  input  logic                    tx_done_tick
);

  localparam int PTR_W = cnt_width(NUM_REQ);
  localparam int CNT_W = cnt_width(MAX_BURST);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [DBIT-1:0]    tx_din_q, tx_din_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic               last_q, last_d;
  logic               tx_start_q, tx_start_d;

  logic [NUM_REQ-1:0] pick;
  logic               any_req;
  logic [PTR_W-1:0]   g_idx;
  logic [PTR_W-1:0]   g_next;
  logic [DBIT-1:0]    g_data;
  logic               g_valid;
  logic               g_last;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .pick   (pick),
    .any    (any_req)
  );

  // Decode the one-hot owner into its index and its requester's handshake signals.
  always_comb begin
    g_idx   = '0;
    g_data  = '0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        g_idx   = PTR_W'(i);
        g_data  = req_data[i*DBIT +: DBIT];
        g_valid = req_valid[i];
        g_last  = req_last[i];
      end
    end
  end

  assign g_next = (g_idx == PTR_MAX) ? '0 : g_idx + 1'b1;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    tx_din_d    = tx_din_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    last_d      = last_q;
    tx_start_d  = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          grant_d     = pick;
          burst_cnt_d = '0;
          state_d     = ARB_SEND;
        end
      end
      ARB_SEND: begin
        if (g_valid) begin
          tx_din_d   = g_data;
          last_d     = g_last;
          tx_start_d = 1'b1;
          state_d    = ARB_WAIT;
        end else begin
          // Owner went quiet: the burst is over and the next requester gets priority.
          grant_d  = '0;
          rr_ptr_d = g_next;
          state_d  = ARB_IDLE;
        end
      end
      ARB_WAIT: begin
        if (tx_done_tick) begin
          if (last_q || burst_cnt_q == CNT_MAX) begin
            grant_d  = '0;
            rr_ptr_d = g_next;
            state_d  = ARB_IDLE;
          end else begin
            burst_cnt_d = burst_cnt_q + 1'b1;
            state_d     = ARB_SEND;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      tx_din_q    <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      last_q      <= 1'b0;
      tx_start_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      tx_din_q    <= tx_din_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      last_q      <= last_d;
      tx_start_q  <= tx_start_d;
    end
  end

  assign req_ready = (state_q == ARB_SEND && g_valid) ? grant_q : '0;
  assign grant     = grant_q;
  assign busy      = (state_q != ARB_IDLE);
  assign tx_start  = tx_start_q;
  assign tx_din    = tx_din_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed timing scenarios plus randomized
// byte queues scored against a burst-level round-robin reference model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NR   = 4;
  localparam int DB   = 8;
  localparam int MAXB = 4;
  localparam int NRB  = 3;

  typedef struct packed {
    logic          last;
    logic [DB-1:0] data;
  } item_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NR-1:0]    a_req_valid;
  logic [NR*DB-1:0] a_req_data;
  logic [NR-1:0]    a_req_last;
  logic [NR-1:0]    a_req_ready;
  logic [NR-1:0]    a_grant;
  logic             a_busy;
  logic             a_tx_start;
  logic [DB-1:0]    a_tx_din;
  logic             a_tx_done_tick;

  logic [NRB-1:0]    b_req_valid;
  logic [NRB*DB-1:0] b_req_data;
  logic [NRB-1:0]    b_req_last;
  logic [NRB-1:0]    b_req_ready;
  logic [NRB-1:0]    b_grant;
  logic              b_busy;
  logic              b_tx_start;
  logic [DB-1:0]     b_tx_din;
  logic              b_tx_done_tick;

  uart_tx_arbiter #(.NUM_REQ(NR), .DBIT(DB), .MAX_BURST(MAXB)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (a_req_valid),
    .req_data     (a_req_data),
    .req_last     (a_req_last),
    .req_ready    (a_req_ready),
    .grant        (a_grant),
    .busy         (a_busy),
    .tx_start     (a_tx_start),
    .tx_din       (a_tx_din),
    .tx_done_tick (a_tx_done_tick)
  );

  uart_tx_arbiter #(.NUM_REQ(NRB), .DBIT(DB), .MAX_BURST(16)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (b_req_valid),
    .req_data     (b_req_data),
    .req_last     (b_req_last),
    .req_ready    (b_req_ready),
    .grant        (b_grant),
    .busy         (b_busy),
    .tx_start     (b_tx_start),
    .tx_din       (b_tx_din),
    .tx_done_tick (b_tx_done_tick)
  );

  int vectors     = 0;
  int miscompares = 0;

  item_t         q [NR][$];
  int            exp_owner [$];
  logic [DB-1:0] exp_byte [$];
  int            m_ptr;
  bit            tx_auto;
  int            tx_lat;
  int            tx_wait;
  logic          next_done;
  logic [DB-1:0] last_started;
  int            b_wait;
  logic          b_next;

  function automatic int onehot_idx(input logic [7:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit any_queued();
    for (int i = 0; i < NR; i++) if (q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // Each requester presents the head of its queue and holds it until accepted.
  task automatic drive_a();
    item_t h;
    for (int i = 0; i < NR; i++) begin
      if (q[i].size() > 0) begin
        h = q[i][0];
        a_req_valid[i]          = 1'b1;
        a_req_data[i*DB +: DB]  = h.data;
        a_req_last[i]           = h.last;
      end else begin
        a_req_valid[i]          = 1'b0;
        a_req_data[i*DB +: DB]  = '0;
        a_req_last[i]           = 1'b0;
      end
    end
  endtask

  // One clock for instance A: retire accepted bytes, run the transmitter model, re-drive.
  task automatic tick();
    logic [NR-1:0] rdy;
    logic          st;
    rdy = a_req_ready;
    st  = a_tx_start;
    if (st && tx_auto) tx_wait = tx_lat;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (rdy[i] && q[i].size() > 0) void'(q[i].pop_front());
    a_tx_done_tick = next_done;
    next_done      = 1'b0;
    if (tx_wait > 0) begin
      tx_wait--;
      if (tx_wait == 0) next_done = 1'b1;
    end
    drive_a();
    #1;
  endtask

  task automatic b_tick();
    logic [NRB-1:0] rdy;
    rdy = b_req_ready;
    if (b_tx_start) b_wait = 2;
    @(posedge clk);
    #1;
    b_req_valid    = b_req_valid & ~rdy;
    b_tx_done_tick = b_next;
    b_next         = 1'b0;
    if (b_wait > 0) begin
      b_wait--;
      if (b_wait == 0) b_next = 1'b1;
    end
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    for (int i = 0; i < NR; i++) q[i].delete();
    tx_wait        = 0;
    next_done      = 1'b0;
    a_tx_done_tick = 1'b0;
    b_req_valid    = '0;
    b_tx_done_tick = 1'b0;
    b_next         = 1'b0;
    b_wait         = 0;
    drive_a();
    tick();
    tick();
    reset = 1'b0;
    m_ptr = 0;
  endtask

  // Reference: serve whole bursts from the queues by round-robin priority.
  task automatic build_expected();
    item_t mq [NR][$];
    item_t it;
    int    owner;
    int    cnt;
    bit    stop;
    for (int i = 0; i < NR; i++) mq[i] = q[i];
    exp_owner.delete();
    exp_byte.delete();
    while (1) begin
      owner = -1;
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (m_ptr + k) % NR;
        if (owner < 0 && mq[j].size() > 0) owner = j;
      end
      if (owner < 0) break;
      cnt  = 0;
      stop = 1'b0;
      while (!stop) begin
        it = mq[owner].pop_front();
        exp_owner.push_back(owner);
        exp_byte.push_back(it.data);
        cnt++;
        stop = it.last || cnt == MAXB || mq[owner].size() == 0;
      end
      m_ptr = (owner + 1) % NR;
    end
  endtask

  // Run instance A with the automatic transmitter until every queue is drained.
  task automatic drain(input string name, input int budget);
    int            n;
    int            o;
    int            got;
    logic [DB-1:0] b;
    n       = 0;
    tx_auto = 1'b1;
    drive_a();
    #1;
    while ((any_queued() || a_busy || tx_wait != 0 || next_done) && n < budget) begin
      if (a_tx_start) begin
        vectors++;
        got = onehot_idx(8'(a_grant));
        if (exp_byte.size() == 0) begin
          miscompares++;
          $display("FAIL %s: unexpected byte %02h from owner %0d, none expected", name, a_tx_din, got);
        end else begin
          o = exp_owner.pop_front();
          b = exp_byte.pop_front();
          last_started = b;
          if (got != o || a_tx_din !== b) begin
            miscompares++;
            $display("FAIL %s: sent owner %0d byte %02h, expected owner %0d byte %02h",
                     name, got, a_tx_din, o, b);
          end
        end
      end
      if (a_tx_done_tick) begin
        vectors++;
        if (a_tx_din !== last_started) begin
          miscompares++;
          $display("FAIL %s tx_din hold: got %02h, expected %02h", name, a_tx_din, last_started);
        end
      end
      vectors++;
      if ((a_req_ready & ~a_grant) != '0 || $countones(a_req_ready) > 1) begin
        miscompares++;
        $display("FAIL %s req_ready: got %b with grant %b, expected subset of one-hot grant",
                 name, a_req_ready, a_grant);
      end
      tick();
      n++;
    end
    vectors++;
    if (n >= budget || exp_byte.size() != 0) begin
      miscompares++;
      $display("FAIL %s completion: %0d cycles used, %0d bytes still expected, required done within %0d with 0 left",
               name, n, exp_byte.size(), budget);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (a_grant !== '0 || a_busy !== 1'b0 || a_tx_start !== 1'b0 || a_tx_din !== '0 || a_req_ready !== '0) begin
      miscompares++;
      $display("FAIL reset_a: grant %b busy %b start %b din %02h ready %b, expected all zero",
               a_grant, a_busy, a_tx_start, a_tx_din, a_req_ready);
    end
    vectors++;
    if (b_grant !== '0 || b_busy !== 1'b0 || b_tx_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_b: grant %b busy %b start %b, expected all zero", b_grant, b_busy, b_tx_start);
    end
  endtask

  task automatic test_single_byte();
    item_t it;
    tx_auto = 1'b0;
    it.last = 1'b1;
    it.data = 8'hA5;
    q[1].push_back(it);
    drive_a();
    #1;
    vectors++;
    if (a_grant !== 4'b0000 || a_req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL single idle: grant %b ready %b, expected 0000 0000", a_grant, a_req_ready);
    end
    tick();
    vectors++;
    if (a_grant !== 4'b0010 || a_req_ready !== 4'b0010 || a_tx_start !== 1'b0) begin
      miscompares++;
      $display("FAIL single accept: grant %b ready %b start %b, expected 0010 0010 0", a_grant, a_req_ready, a_tx_start);
    end
    tick();
    vectors++;
    if (a_tx_start !== 1'b1 || a_tx_din !== 8'hA5 || a_req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL single start: start %b din %02h ready %b, expected 1 a5 0000", a_tx_start, a_tx_din, a_req_ready);
    end
    tick();
    vectors++;
    if (a_tx_start !== 1'b0 || a_tx_din !== 8'hA5 || a_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single wait: start %b din %02h busy %b, expected 0 a5 1", a_tx_start, a_tx_din, a_busy);
    end
    next_done = 1'b1;
    tick();
    tick();
    vectors++;
    if (a_grant !== 4'b0000 || a_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single release: grant %b busy %b, expected 0000 0", a_grant, a_busy);
    end
    // Requester 1 finished, so priority now starts at requester 2.
    m_ptr   = 2;
    it.data = 8'h01;
    q[0].push_back(it);
    it.data = 8'h02;
    q[2].push_back(it);
    tx_lat = 1;
    build_expected();
    drain("single_next", 200);
  endtask

  task automatic test_valid_drop();
    item_t it;
    tx_auto = 1'b0;
    it.last = 1'b0;
    it.data = 8'h55;
    q[3].push_back(it);
    drive_a();
    #1;
    tick();
    tick();
    vectors++;
    if (a_tx_start !== 1'b1 || a_tx_din !== 8'h55 || a_req_valid !== 4'b0000) begin
      miscompares++;
      $display("FAIL drop start: start %b din %02h, expected 1 55", a_tx_start, a_tx_din);
    end
    tick();
    next_done = 1'b1;
    tick();
    tick();
    vectors++;
    if (a_busy !== 1'b1 || a_grant !== 4'b1000 || a_req_ready !== 4'b0000 || a_tx_start !== 1'b0) begin
      miscompares++;
      $display("FAIL drop send: busy %b grant %b ready %b start %b, expected 1 1000 0000 0",
               a_busy, a_grant, a_req_ready, a_tx_start);
    end
    tick();
    vectors++;
    if (a_busy !== 1'b0 || a_grant !== 4'b0000 || a_tx_start !== 1'b0) begin
      miscompares++;
      $display("FAIL drop release: busy %b grant %b start %b, expected 0 0000 0", a_busy, a_grant, a_tx_start);
    end
    m_ptr = 0;
  endtask

  task automatic test_round_robin();
    item_t it;
    apply_reset();
    it.last = 1'b1;
    for (int i = 0; i < NR; i++) begin
      it.data = 8'h10 + 8'(i);
      q[i].push_back(it);
    end
    it.data = 8'h20;
    q[0].push_back(it);
    tx_lat = 2;
    build_expected();
    drain("round_robin", 400);
  endtask

  task automatic test_burst_cap();
    item_t it;
    apply_reset();
    it.last = 1'b0;
    for (int k = 0; k < 6; k++) begin
      it.data = 8'(k);
      q[0].push_back(it);
    end
    it.last = 1'b1;
    it.data = 8'h22;
    q[2].push_back(it);
    tx_lat = 2;
    build_expected();
    drain("burst_cap", 400);
  endtask

  task automatic test_reset_stray();
    item_t it;
    tx_auto = 1'b0;
    it.last = 1'b1;
    it.data = 8'h77;
    q[1].push_back(it);
    drive_a();
    #1;
    tick();
    tick();
    vectors++;
    if (a_tx_start !== 1'b1 || a_tx_din !== 8'h77) begin
      miscompares++;
      $display("FAIL stray wait: start %b din %02h, expected 1 77", a_tx_start, a_tx_din);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (a_grant !== '0 || a_busy !== 1'b0 || a_tx_start !== 1'b0 || a_tx_din !== '0 || a_req_ready !== '0) begin
      miscompares++;
      $display("FAIL reset in wait: grant %b busy %b start %b din %02h ready %b, expected all zero",
               a_grant, a_busy, a_tx_start, a_tx_din, a_req_ready);
    end
    // The transmitter finishes the in-flight byte after the arbiter was reset.
    next_done = 1'b1;
    tick();
    tick();
    vectors++;
    if (a_busy !== 1'b0 || a_grant !== '0 || a_tx_start !== 1'b0) begin
      miscompares++;
      $display("FAIL stray idle: busy %b grant %b start %b, expected 0 0000 0", a_busy, a_grant, a_tx_start);
    end
    it.data = 8'h66;
    q[2].push_back(it);
    next_done = 1'b1;
    tick();
    tick();
    vectors++;
    if (a_grant !== 4'b0100 || a_req_ready !== 4'b0100 || a_tx_start !== 1'b0) begin
      miscompares++;
      $display("FAIL stray grant: grant %b ready %b start %b, expected 0100 0100 0", a_grant, a_req_ready, a_tx_start);
    end
    tick();
    vectors++;
    if (a_tx_start !== 1'b1 || a_tx_din !== 8'h66 || a_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL stray send: start %b din %02h busy %b, expected 1 66 1", a_tx_start, a_tx_din, a_busy);
    end
    tick();
    next_done = 1'b1;
    tick();
    tick();
    vectors++;
    if (a_busy !== 1'b0 || a_grant !== 4'b0000) begin
      miscompares++;
      $display("FAIL stray finish: busy %b grant %b, expected 0 0000", a_busy, a_grant);
    end
    m_ptr = 3;
  endtask

  task automatic test_wrap();
    int            exp_g [4];
    logic [DB-1:0] exp_b [4];
    int            seen;
    int            n;
    int            got;
    exp_g = '{2, 0, 1, 2};
    exp_b = '{8'h32, 8'h30, 8'h31, 8'h32};
    seen  = 0;
    n     = 0;
    b_req_data  = {8'h32, 8'h31, 8'h30};
    b_req_last  = '1;
    b_req_valid = 3'b100;
    #1;
    b_tick();
    vectors++;
    if (b_grant !== 3'b100) begin
      miscompares++;
      $display("FAIL wrap first: grant %b, expected 100", b_grant);
    end
    while (b_req_valid != '0 && n < 50) begin
      b_tick();
      n++;
    end
    b_req_valid = 3'b111;
    #1;
    while ((b_req_valid != '0 || b_busy) && n < 300) begin
      if (b_tx_start) begin
        vectors++;
        got = onehot_idx(8'(b_grant));
        if (seen >= 4) begin
          miscompares++;
          $display("FAIL wrap extra: owner %0d byte %02h, expected no more", got, b_tx_din);
        end else if (got != exp_g[seen] || b_tx_din !== exp_b[seen]) begin
          miscompares++;
          $display("FAIL wrap order %0d: owner %0d byte %02h, expected owner %0d byte %02h",
                   seen, got, b_tx_din, exp_g[seen], exp_b[seen]);
        end
        seen++;
      end
      b_tick();
      n++;
    end
    vectors++;
    if (seen != 4 || n >= 300) begin
      miscompares++;
      $display("FAIL wrap count: %0d bytes in %0d cycles, expected 4 within 300", seen, n);
    end
  endtask

  task automatic test_random();
    item_t it;
    int    len;
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < NR; i++) begin
        len = $urandom_range(0, 7);
        for (int k = 0; k < len; k++) begin
          it.data = DB'($urandom);
          it.last = ($urandom_range(0, 3) == 0);
          q[i].push_back(it);
        end
      end
      tx_lat = $urandom_range(1, 4);
      build_expected();
      drain("random", 2000);
    end
  endtask

  initial begin
    reset          = 1'b1;
    a_req_valid    = '0;
    a_req_data     = '0;
    a_req_last     = '0;
    a_tx_done_tick = 1'b0;
    b_req_valid    = '0;
    b_req_data     = '0;
    b_req_last     = '0;
    b_tx_done_tick = 1'b0;
    tx_auto        = 1'b0;
    tx_lat         = 1;
    tx_wait        = 0;
    next_done      = 1'b0;
    last_started   = '0;
    b_wait         = 0;
    b_next         = 1'b0;
    m_ptr          = 0;

    test_reset();
    test_single_byte();
    test_valid_drop();
    test_round_robin();
    test_burst_cap();
    test_reset_stray();
    test_wrap();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
